song_sequencer: RTL and testbench
=================================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 Parameter BEAT_CYCLES, default 50000000, clock cycles per beat.
REQ-002 Parameter GAP_CYCLES, default 2500000, silent cycles between notes (used only with NOTE_GAP_EN).
REQ-003 CLOCK_50  in  1  single clock, rising edge.
REQ-004 Reset  in  1  asynchronous, active-high.
REQ-005 start  in  1  level; sampled only in IDLE; begins selected song.
REQ-006 stop  in  1  abort playback; has priority over start.
REQ-007 song_sel  in  1  0 = twinkle, 1 = hot cross buns; latched on accepted start.
REQ-008 note_delay  out  20  half-period count for the downstream tone generator; 0 when silent.
REQ-009 note_en  out  1  tone enable for the downstream tone generator.
REQ-010 note_idx  out  4  index of the current song entry.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  single-cycle pulse on natural song completion.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 FSM states SHALL be IDLE, LOAD, PLAY, GAP, DONE.
REQ-015 Song entry format: 3-bit note code (0 REST, 1 C4, 2 D4, 3 E4, 4 F4, 5 G4, 6 A4, 7 B4) plus 3-bit beats; beats = 0 is the end marker.
REQ-016 Half-periods: C4 191113, D4 170262, E4 151686, F4 143173, G4 127553, A4 113636, B4 101238.
REQ-017 Twinkle song: C4x2, G4x2, A4x2, G4x1, F4x2, E4x2, D4x2, C4x2, end.
REQ-018 Hot cross buns song: E4x1, D4x1, C4x1, G4x1, F4x1, E4x1, D4x3, C4x4, end.
REQ-019 IDLE with start=1 and stop=0 at edge k: the FSM SHALL enter LOAD with note_idx=0; note_en/note_delay SHALL be valid after edge k+1.
REQ-020 LOAD: beats=0 goes to DONE; otherwise PLAY for exactly beats*BEAT_CYCLES cycles.
REQ-021 PLAY with REST: note_en=0 and note_delay=0, with timing unchanged.
REQ-022 At the end of PLAY: note_idx increments and the FSM goes to LOAD (or GAP, see REQ-030). LOAD costs no audible cycle, because the outputs hold until the new entry is registered.
REQ-023 After entry 15 with no end marker, the FSM SHALL go to DONE; note_idx SHALL NOT wrap.
REQ-024 DONE: done=1 for one cycle, note_en=0, then IDLE.
REQ-025 stop=1 in any non-IDLE state: the FSM SHALL be in IDLE after the next edge, with note_en=0, note_delay=0 and no done pulse.
REQ-026 start while busy is ignored; a song_sel change while busy is ignored.
REQ-027 Beat and gap counters SHALL be wide enough for 7*BEAT_CYCLES without overflow.

Reset
REQ-028 Reset asserted: state=IDLE, note_delay=0, note_en=0, note_idx=0, busy=0, done=0, counters=0, immediately and regardless of clock.
REQ-029 Reset mid-song: playback is abandoned; after release the block SHALL wait for a new start.

Configuration
REQ-030 With NOTE_GAP_EN defined: after each non-final PLAY, the FSM SHALL enter GAP for GAP_CYCLES with note_en=0 and note_delay=0, then LOAD. Without NOTE_GAP_EN: the GAP state and its counter are absent, and notes are contiguous.

Structure
REQ-031 Package song_pkg SHALL hold the note-code enum, the half-period constants, the song entry typedef, the FSM state typedef, and the song ROM lookup function (song_sel, idx) -> entry.
REQ-032 One sub-module, beat_timer, SHALL count BEAT_CYCLES and emit a beat tick; the FSM counts remaining beats.

Verification (BEAT_CYCLES=10, GAP_CYCLES=2)
REQ-033 song_sel=0, start pulse, no gap: note_delay SHALL be 191113 for 20 cycles, then 127553 for 20, then 113636 for 20, and so on. Total audible time SHALL be 150 cycles, with done pulsing once and busy falling after it.
REQ-034 song_sel=1: first note SHALL be 151686 for 10 cycles; the final C4 (191113) SHALL last 40 cycles; total 130 cycles, then done.
REQ-035 NOTE_GAP_EN, song_sel=0: note_en SHALL be low for 2 cycles between each of the 8 notes; done at 150 + 7*2 cycles.
REQ-036 stop asserted 5 cycles into the G4 note: note_en=0 on the next cycle, IDLE, no done pulse; a following start SHALL replay from note_idx=0.
REQ-037 start re-pulsed mid-song with song_sel toggled: no effect, and the original song SHALL complete.
REQ-038 Reset asserted asynchronously mid-note: note_en and busy SHALL drop before the next clock edge; start and stop applied in the same cycle SHALL leave the block in IDLE.

Source files
------------

// File: rtl/song_pkg.sv
// song_pkg: shared types and constants for the song sequencer.
// Holds note codes, tone half-periods, the song entry format, FSM states
// and the song ROM lookup. The GAP state exists only when NOTE_GAP_EN is defined.
package song_pkg;

  typedef enum logic [2:0] {
    NOTE_REST = 3'd0,
    NOTE_C4   = 3'd1,
    NOTE_D4   = 3'd2,
    NOTE_E4   = 3'd3,
    NOTE_F4   = 3'd4,
    NOTE_G4   = 3'd5,
    NOTE_A4   = 3'd6,
    NOTE_B4   = 3'd7
  } note_e;

  localparam logic [19:0] HP_C4 = 20'd191113;
  localparam logic [19:0] HP_D4 = 20'd170262;
  localparam logic [19:0] HP_E4 = 20'd151686;
  localparam logic [19:0] HP_F4 = 20'd143173;
  localparam logic [19:0] HP_G4 = 20'd127553;
  localparam logic [19:0] HP_A4 = 20'd113636;
  localparam logic [19:0] HP_B4 = 20'd101238;

  // One song step: beats == 0 marks the end of the song.
  typedef struct packed {
    note_e      note;
    logic [2:0] beats;
  } entry_t;

`ifdef NOTE_GAP_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    DONE = 3'd4
  } state_e;
`endif

  // Tone half-period for a note code; rests are silent (0).
  function automatic logic [19:0] half_period(input note_e n);
    logic [19:0] hp;
    case (n)
      NOTE_C4: hp = HP_C4;
      NOTE_D4: hp = HP_D4;
      NOTE_E4: hp = HP_E4;
      NOTE_F4: hp = HP_F4;
      NOTE_G4: hp = HP_G4;
      NOTE_A4: hp = HP_A4;
      NOTE_B4: hp = HP_B4;
      default: hp = 20'd0;
    endcase
    return hp;
  endfunction

  // Song ROM: sel 0 = twinkle, sel 1 = hot cross buns. Unused slots are end markers.
  function automatic entry_t song_rom(input logic sel, input logic [3:0] idx);
    entry_t e;
    e = '{note: NOTE_REST, beats: 3'd0};
    if (sel == 1'b0) begin
      case (idx)
        4'd0:    e = '{note: NOTE_C4, beats: 3'd2};
        4'd1:    e = '{note: NOTE_G4, beats: 3'd2};
        4'd2:    e = '{note: NOTE_A4, beats: 3'd2};
        4'd3:    e = '{note: NOTE_G4, beats: 3'd1};
        4'd4:    e = '{note: NOTE_F4, beats: 3'd2};
        4'd5:    e = '{note: NOTE_E4, beats: 3'd2};
        4'd6:    e = '{note: NOTE_D4, beats: 3'd2};
        4'd7:    e = '{note: NOTE_C4, beats: 3'd2};
        default: e = '{note: NOTE_REST, beats: 3'd0};
      endcase
    end else begin
      case (idx)
        4'd0:    e = '{note: NOTE_E4, beats: 3'd1};
        4'd1:    e = '{note: NOTE_D4, beats: 3'd1};
        4'd2:    e = '{note: NOTE_C4, beats: 3'd1};
        4'd3:    e = '{note: NOTE_G4, beats: 3'd1};
        4'd4:    e = '{note: NOTE_F4, beats: 3'd1};
        4'd5:    e = '{note: NOTE_E4, beats: 3'd1};
        4'd6:    e = '{note: NOTE_D4, beats: 3'd3};
        4'd7:    e = '{note: NOTE_C4, beats: 3'd4};
        default: e = '{note: NOTE_REST, beats: 3'd0};
      endcase
    end
    return e;
  endfunction

  // Beat count of an entry, for look-ahead at the following entry.
  function automatic logic [2:0] entry_beats(input logic sel, input logic [3:0] idx);
    entry_t e;
    e = song_rom(sel, idx);
    return e.beats;
  endfunction

endpackage

// File: rtl/song_sequencer_beat_timer.sv
// beat_timer: free-running divider that pulses tick on the last cycle of
// every BEAT_CYCLES window while enabled; disabled means held at zero so a
// new note always starts a fresh beat. Expects BEAT_CYCLES >= 2.
module beat_timer #(
  parameter int BEAT_CYCLES = 50000000
) (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_r;
  logic             wrap_s;

  assign wrap_s = (cnt_r == CNT_W'(BEAT_CYCLES - 1));
  assign tick   = en && wrap_s;

  // Cycle counter within the current beat, cleared whenever not enabled.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      cnt_r <= '0;
    end else if (!en) begin
      cnt_r <= '0;
    end else if (wrap_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: plays one of two ROM songs as note half-periods for a
// downstream tone generator. Optional silent gaps between notes are enabled
// with the NOTE_GAP_EN macro. All outputs come straight from registers.
//
// Timing: the beat timer runs in LOAD and PLAY, so one LOAD cycle plus the
// PLAY cycles make up exactly beats*BEAT_CYCLES. The outputs are updated on
// the edge leaving LOAD, and they hold through the following LOAD (or first
// GAP cycle), so each note is audible for exactly beats*BEAT_CYCLES cycles.
module song_sequencer
  import song_pkg::*;
#(
  parameter int BEAT_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 2500000
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic        start,
  input  logic        stop,
  input  logic        song_sel,
  output logic [19:0] note_delay,
  output logic        note_en,
  output logic [3:0]  note_idx,
  output logic        busy,
  output logic        done
);

  state_e      state_r, next_state_s;
  logic        sel_r;
  logic [3:0]  idx_r;
  logic [2:0]  beats_left_r;
  logic        last_r;
  logic [19:0] delay_r, delay_nxt_s;
  logic        en_r, en_nxt_s;
  logic        busy_r, done_r;
  entry_t      cur_entry_s;
  logic        tick_s, timer_en_s, play_end_s;

  assign cur_entry_s = song_rom(sel_r, idx_r);
  assign timer_en_s  = (state_r == LOAD) || (state_r == PLAY);
  assign play_end_s  = tick_s && (beats_left_r == 3'd1);

  beat_timer #(.BEAT_CYCLES(BEAT_CYCLES)) u_beat_timer (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .en       (timer_en_s),
    .tick     (tick_s)
  );

`ifdef NOTE_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             gap_done_s;
  logic             final_s;

  assign gap_done_s = (gap_cnt_r == GAP_W'(GAP_CYCLES - 1));
  // No gap after the last note: either slot 15 or the next entry is the end marker.
  assign final_s    = (idx_r == 4'd15) || (entry_beats(sel_r, idx_r + 4'd1) == 3'd0);

  // Silent-cycle counter, only running while in GAP.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      gap_cnt_r <= '0;
    end else if ((state_r == GAP) && !gap_done_s) begin
      gap_cnt_r <= gap_cnt_r + GAP_W'(1);
    end else begin
      gap_cnt_r <= '0;
    end
  end
`endif

  // Next-state logic; stop wins over everything outside IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && !stop) next_state_s = LOAD;
        else                next_state_s = IDLE;
      end
      LOAD: begin
        if (stop)                                          next_state_s = IDLE;
        else if (last_r || (cur_entry_s.beats == 3'd0))    next_state_s = DONE;
        else                                               next_state_s = PLAY;
      end
      PLAY: begin
        if (stop) begin
          next_state_s = IDLE;
        end else if (play_end_s) begin
`ifdef NOTE_GAP_EN
          if (final_s) next_state_s = LOAD;
          else         next_state_s = GAP;
`else
          next_state_s = LOAD;
`endif
        end else begin
          next_state_s = PLAY;
        end
      end
`ifdef NOTE_GAP_EN
      GAP: begin
        if (stop)            next_state_s = IDLE;
        else if (gap_done_s) next_state_s = LOAD;
        else                 next_state_s = GAP;
      end
`endif
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Next tone outputs: load on LOAD->PLAY, silence on exit/finish/gap, else hold.
  always_comb begin
    delay_nxt_s = delay_r;
    en_nxt_s    = en_r;
    if ((next_state_s == IDLE) || (next_state_s == DONE)) begin
      delay_nxt_s = 20'd0;
      en_nxt_s    = 1'b0;
    end else if ((state_r == LOAD) && (next_state_s == PLAY)) begin
      delay_nxt_s = half_period(cur_entry_s.note);
      en_nxt_s    = (cur_entry_s.note != NOTE_REST);
`ifdef NOTE_GAP_EN
    end else if (state_r == GAP) begin
      delay_nxt_s = 20'd0;
      en_nxt_s    = 1'b0;
`endif
    end else begin
      delay_nxt_s = delay_r;
      en_nxt_s    = en_r;
    end
  end

  // State, song position and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_r      <= IDLE;
      sel_r        <= 1'b0;
      idx_r        <= 4'd0;
      beats_left_r <= 3'd0;
      last_r       <= 1'b0;
      delay_r      <= 20'd0;
      en_r         <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r <= next_state_s;
      delay_r <= delay_nxt_s;
      en_r    <= en_nxt_s;
      busy_r  <= (next_state_s != IDLE);
      done_r  <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (next_state_s == LOAD) begin
            sel_r  <= song_sel;
            idx_r  <= 4'd0;
            last_r <= 1'b0;
          end
        end
        LOAD: beats_left_r <= cur_entry_s.beats;
        PLAY: begin
          if (tick_s) beats_left_r <= beats_left_r - 3'd1;
          if (play_end_s) begin
            if (idx_r == 4'd15) last_r <= 1'b1;
            else                idx_r  <= idx_r + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign note_delay = delay_r;
  assign note_en    = en_r;
  assign note_idx   = idx_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed bench for song_sequencer with BEAT_CYCLES=10,
// GAP_CYCLES=2. Outputs are sampled on the falling clock edge.
module tb_song_sequencer;

  localparam int BEAT = 10;
  localparam int GAPC = 2;
`ifdef NOTE_GAP_EN
  localparam int GAP_N = GAPC;
`else
  localparam int GAP_N = 0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        Reset;
  logic        start, stop, song_sel;
  logic [19:0] note_delay;
  logic        note_en;
  logic [3:0]  note_idx;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

  logic [19:0] exp_delay [2][8] = '{
    '{20'd191113, 20'd127553, 20'd113636, 20'd127553, 20'd143173, 20'd151686, 20'd170262, 20'd191113},
    '{20'd151686, 20'd170262, 20'd191113, 20'd127553, 20'd143173, 20'd151686, 20'd170262, 20'd191113}
  };
  int exp_beats [2][8] = '{
    '{2, 2, 2, 1, 2, 2, 2, 2},
    '{1, 1, 1, 1, 1, 1, 3, 4}
  };

  song_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC)) dut (
    .CLOCK_50   (CLOCK_50),
    .Reset      (Reset),
    .start      (start),
    .stop       (stop),
    .song_sel   (song_sel),
    .note_delay (note_delay),
    .note_en    (note_en),
    .note_idx   (note_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Start a song and follow it note by note to the done pulse.
  // With disturb set, start is re-pulsed with the other song_sel mid-song.
  task automatic play_song(input logic sel, input bit disturb);
    int s;
    s = int'(sel);
    @(negedge CLOCK_50);
    song_sel = sel;
    start    = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    chk($sformatf("load_busy_s%0d", s), {31'd0, busy}, 32'd1);
    chk($sformatf("load_en_s%0d", s), {31'd0, note_en}, 32'd0);
    chk($sformatf("load_idx_s%0d", s), {28'd0, note_idx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      int len;
      int bad;
      len = exp_beats[s][i] * BEAT;
      bad = 0;
      for (int c = 0; c < len; c++) begin
        @(negedge CLOCK_50);
        if (c == 0) chk($sformatf("idx_s%0d_n%0d", s, i), {28'd0, note_idx}, i);
        if (!(note_en === 1'b1 && note_delay === exp_delay[s][i] && done === 1'b0 && busy === 1'b1))
          bad++;
        if (disturb && i == 2) begin
          if (c == 0) begin
            start    = 1'b1;
            song_sel = ~sel;
          end else begin
            start = 1'b0;
          end
        end
      end
      chk($sformatf("note_s%0d_n%0d_badcycles", s, i), bad, 32'd0);
      if (i < 7 && GAP_N > 0) begin
        bad = 0;
        for (int g = 0; g < GAP_N; g++) begin
          @(negedge CLOCK_50);
          if (!(note_en === 1'b0 && note_delay === 20'd0 && done === 1'b0 && busy === 1'b1))
            bad++;
        end
        chk($sformatf("gap_s%0d_n%0d_badcycles", s, i), bad, 32'd0);
      end
    end
    @(negedge CLOCK_50);
    chk($sformatf("done_pulse_s%0d", s), {31'd0, done}, 32'd1);
    chk($sformatf("done_en_s%0d", s), {31'd0, note_en}, 32'd0);
    chk($sformatf("done_busy_s%0d", s), {31'd0, busy}, 32'd1);
    @(negedge CLOCK_50);
    chk($sformatf("after_done_s%0d", s), {31'd0, done}, 32'd0);
    chk($sformatf("after_busy_s%0d", s), {31'd0, busy}, 32'd0);
    song_sel = sel;
  endtask

  initial begin
    int bad;
    start    = 1'b0;
    stop     = 1'b0;
    song_sel = 1'b0;
    Reset    = 1'b1;
    #1;
    chk("rst_delay", {12'd0, note_delay}, 32'd0);
    chk("rst_en", {31'd0, note_en}, 32'd0);
    chk("rst_idx", {28'd0, note_idx}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge CLOCK_50);
    Reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);

    // Both songs, undisturbed.
    play_song(1'b0, 1'b0);
    play_song(1'b1, 1'b0);

    // Stop five cycles into the G4 note of twinkle.
    @(negedge CLOCK_50);
    song_sel = 1'b0;
    start    = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (20 + GAP_N + 5) @(negedge CLOCK_50);
    chk("pre_stop_g4", {12'd0, note_delay}, 32'd127553);
    stop = 1'b1;
    @(negedge CLOCK_50);
    stop = 1'b0;
    chk("stop_en", {31'd0, note_en}, 32'd0);
    chk("stop_delay", {12'd0, note_delay}, 32'd0);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLOCK_50);
      if (done !== 1'b0 || busy !== 1'b0 || note_en !== 1'b0) bad++;
    end
    chk("stop_quiet_cycles", bad, 32'd0);

    // Replay from the top, then a disturbed run of song 1.
    play_song(1'b0, 1'b0);
    play_song(1'b1, 1'b1);

    // Asynchronous reset mid-note.
    @(negedge CLOCK_50);
    song_sel = 1'b0;
    start    = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (7) @(negedge CLOCK_50);
    chk("mid_note_en", {31'd0, note_en}, 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_en", {31'd0, note_en}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_delay", {12'd0, note_delay}, 32'd0);
    @(negedge CLOCK_50);
    Reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    // start and stop together in IDLE: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_busy", {31'd0, busy}, 32'd0);
    chk("start_stop_en", {31'd0, note_en}, 32'd0);
    @(negedge CLOCK_50);
    chk("start_stop_busy2", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
